regs_wb: RTL and testbench
==========================

REGS_WB -- requirements
Module: regs_wb

Interface
REQ-001 SHALL have ports (clock and reset first): clk  in  1  rising-edge clock; rst_n  in  1  reset, synchronous, active-low.
REQ-002 SHALL have: clk_en  in  1  global advance enable; no state changes when 0.
REQ-003 SHALL have: i_issue_valid in 1, i_issue_rd in 5: destination register claimed at issue; o_issue_ready out 1: issue accepted.
REQ-004 SHALL have: i_alu_valid in 1, i_alu_rd in 5, i_alu_data in 32: single-cycle ALU result, no back-pressure.
REQ-005 SHALL have: i_ld_valid in 1, o_ld_ready out 1, i_ld_rd in 5, i_ld_data in 32 (raw aligned word), i_ld_funct3 in 3, i_ld_offset in 2: load-return handshake.
REQ-006 SHALL have: o_write_en out 1, o_write_addr out 5, o_write_data out 32: register-file write port.
REQ-007 SHALL have: i_a_addr in 5, i_b_addr in 5, o_a_busy out 1, o_b_busy out 1: source-operand scoreboard query.

Function
REQ-008 Scoreboard SHALL hold busy[31:1]; register x0 is never busy, o_a_busy/o_b_busy are combinational reads of busy (0 for address 0).
REQ-009 o_issue_ready SHALL equal !busy[i_issue_rd] (WAW stall); rd=0 is always ready.
REQ-010 Issue handshake (i_issue_valid & o_issue_ready & clk_en) with rd!=0 SHALL set busy[rd] at the next edge.
REQ-011 Load buffer SHALL be a 1-entry FSM: EMPTY -> FULL on i_ld_valid & o_ld_ready & clk_en; FULL -> EMPTY when the buffered load commits.
REQ-012 o_ld_ready SHALL be 1 in EMPTY and 0 in FULL (registered-state only, no dependence on i_alu_valid).
REQ-013 Buffer SHALL capture rd and extended data at acceptance; extension: 000 LB sign-extend byte[offset], 001 LH sign-extend half[offset[1]], 010 LW word, 100 LBU zero-extend byte, 101 LHU zero-extend half; 011/110/111 SHALL behave as LW.
REQ-014 Write arbitration per clk_en cycle: i_alu_valid wins; buffered load commits only in a cycle with i_alu_valid=0.
REQ-015 Write port SHALL be registered: winner appears on o_write_* at the edge after it wins (1-cycle latency); o_write_en=1 for exactly one cycle per commit.
REQ-016 Commit with rd=0 SHALL be consumed (buffer empties / ALU result dropped) with o_write_en=0 and no scoreboard change.
REQ-017 Commit with rd!=0 SHALL clear busy[rd] at the same edge o_write_en rises.
REQ-018 Same-edge set (issue) and clear (commit) of the same rd SHALL leave busy=1.
REQ-019 Load buffer SHALL accept a new load in the same cycle it commits only if it was EMPTY; FULL -> accept no input until the edge after commit (no pass-through).
REQ-020 With clk_en=0: o_write_en SHALL drop to 0 at the next edge, scoreboard and buffer hold, handshakes are ignored (o_ld_ready/o_issue_ready still reflect state).
REQ-021 o_write_addr/o_write_data SHALL hold last committed values when o_write_en=0.

Reset
REQ-022 rst_n=0 at a rising edge SHALL clear busy[31:1], set buffer EMPTY, o_write_en=0, o_write_addr=0, o_write_data=0, regardless of clk_en.
REQ-023 Reset mid-operation SHALL discard any buffered load and pending scoreboard bits; first cycle after rst_n=1: o_ld_ready=1, o_issue_ready=1.
REQ-024 Reset SHALL take priority over all simultaneous issue, ALU, and load events.

Verification
REQ-025 Issue rd=5, then ALU rd=5 data 0x1234 next cycle -> o_a_busy=1 for a_addr=5 until commit edge; o_write_en=1, addr 5, data 0x00001234 one cycle after ALU valid; busy[5]=0 same edge.
REQ-026 Load word 0x80F0_7F81, offset 1, funct3 000 -> write 0x0000007F; funct3 100 offset 0 -> 0x00000081; funct3 001 offset 2 -> 0xFFFF80F0; funct3 101 offset 2 -> 0x000080F0.
REQ-027 Load accepted while i_alu_valid held 3 cycles -> o_ld_ready=0 for 4 cycles; ALU writes on 3 consecutive cycles, load write follows on 4th write cycle.
REQ-028 Issue rd=7 while busy[7]=1 -> o_issue_ready=0; same cycle commit of rd=7 plus new issue rd=7 -> busy[7] stays 1.
REQ-029 ALU valid rd=0 data 0xFFFFFFFF -> o_write_en stays 0; clk_en=0 with i_ld_valid=1 -> no acceptance, buffer stays EMPTY.
REQ-030 Buffer FULL, busy[3]=1, assert rst_n=0 one cycle -> next cycle o_ld_ready=1, busy all 0, o_write_en=0, no later write of the discarded load.

Source files
------------

// File: rtl/regs_wb_if.sv
// Bus bundle for regs_wb: issue claim, ALU result, load return, register-file
// write port and operand scoreboard query. The master drives the i_* signals
// and the slave (regs_wb) drives the o_* signals.
//
// Handshake rules:
// - Issue: a claim transfers on a clk_en edge where i_issue_valid and
//   o_issue_ready are both 1.
// - Load return: a load transfers on a clk_en edge where i_ld_valid and
//   o_ld_ready are both 1.
// - Ready never depends on valid, and the master holds a valid request
//   stable until it transfers.
// - The ALU result has no ready: it is taken in any clk_en cycle where
//   i_alu_valid is 1.
interface regs_wb_if;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic        o_issue_ready;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_ld_valid;
  logic        o_ld_ready;
  logic [4:0]  i_ld_rd;
  logic [31:0] i_ld_data;
  logic [2:0]  i_ld_funct3;
  logic [1:0]  i_ld_offset;
  logic        o_write_en;
  logic [4:0]  o_write_addr;
  logic [31:0] o_write_data;
  logic [4:0]  i_a_addr;
  logic [4:0]  i_b_addr;
  logic        o_a_busy;
  logic        o_b_busy;
  logic        o_dbg_ld_full;

  modport master (
    output i_issue_valid, i_issue_rd, i_alu_valid, i_alu_rd, i_alu_data,
           i_ld_valid, i_ld_rd, i_ld_data, i_ld_funct3, i_ld_offset,
           i_a_addr, i_b_addr,
    input  o_issue_ready, o_ld_ready, o_write_en, o_write_addr, o_write_data,
           o_a_busy, o_b_busy, o_dbg_ld_full
  );

  modport slave (
    input  i_issue_valid, i_issue_rd, i_alu_valid, i_alu_rd, i_alu_data,
           i_ld_valid, i_ld_rd, i_ld_data, i_ld_funct3, i_ld_offset,
           i_a_addr, i_b_addr,
    output o_issue_ready, o_ld_ready, o_write_en, o_write_addr, o_write_data,
           o_a_busy, o_b_busy, o_dbg_ld_full
  );
endinterface

// File: rtl/regs_wb.sv
// Register writeback stage with scoreboard. It tracks which destination
// registers have an in-flight result, and it arbitrates one register-file write
// per cycle. ALU results take priority. A single-entry load buffer holds a
// returned load until the write port is free. o_dbg_ld_full exposes the load
// buffer state.
module regs_wb (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clk_en,
  regs_wb_if.slave bus
);
  typedef enum logic {LD_EMPTY = 1'b0, LD_FULL = 1'b1} ld_state_t;

  ld_state_t   r_ld_state;
  logic [4:0]  r_ld_rd;
  logic [31:0] r_ld_data;
  // Bit 0 is reset and never set, so x0 always reads as not busy.
  logic [31:0] r_busy;
  logic        r_write_en;
  logic [4:0]  r_write_addr;
  logic [31:0] r_write_data;

  logic        w_issue_ready;
  logic        w_issue_fire;
  logic        w_commit;
  logic [4:0]  w_commit_rd;
  logic [31:0] w_commit_data;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_ext;

  assign w_issue_ready = ~r_busy[bus.i_issue_rd];
  assign w_issue_fire  = clk_en & bus.i_issue_valid & w_issue_ready;
  // An ALU result always wins the port. A buffered load uses an idle slot.
  assign w_commit      = clk_en & (bus.i_alu_valid | (r_ld_state == LD_FULL));
  assign w_commit_rd   = bus.i_alu_valid ? bus.i_alu_rd   : r_ld_rd;
  assign w_commit_data = bus.i_alu_valid ? bus.i_alu_data : r_ld_data;

  assign bus.o_issue_ready = w_issue_ready;
  assign bus.o_ld_ready    = (r_ld_state == LD_EMPTY);
  assign bus.o_a_busy      = r_busy[bus.i_a_addr];
  assign bus.o_b_busy      = r_busy[bus.i_b_addr];
  assign bus.o_write_en    = r_write_en;
  assign bus.o_write_addr  = r_write_addr;
  assign bus.o_write_data  = r_write_data;
  assign bus.o_dbg_ld_full = (r_ld_state == LD_FULL);

  // Select the addressed byte or halfword, then extend it according to funct3.
  always_comb begin
    w_ld_byte = bus.i_ld_data[7:0];
    case (bus.i_ld_offset)
      2'd1:    w_ld_byte = bus.i_ld_data[15:8];
      2'd2:    w_ld_byte = bus.i_ld_data[23:16];
      2'd3:    w_ld_byte = bus.i_ld_data[31:24];
      default: w_ld_byte = bus.i_ld_data[7:0];
    endcase
    w_ld_half = bus.i_ld_offset[1] ? bus.i_ld_data[31:16] : bus.i_ld_data[15:0];
    case (bus.i_ld_funct3)
      3'b000:  w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_ext = {24'd0, w_ld_byte};
      3'b101:  w_ld_ext = {16'd0, w_ld_half};
      default: w_ld_ext = bus.i_ld_data;
    endcase
  end

  // Load buffer FSM: a buffer that was full at the start of the cycle cannot
  // accept in that cycle, so a load is never passed straight through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ld_state <= LD_EMPTY;
      r_ld_rd    <= 5'd0;
      r_ld_data  <= 32'd0;
    end else if (clk_en) begin
      case (r_ld_state)
        LD_EMPTY: begin
          if (bus.i_ld_valid) begin
            r_ld_state <= LD_FULL;
            r_ld_rd    <= bus.i_ld_rd;
            r_ld_data  <= w_ld_ext;
          end
        end
        LD_FULL: begin
          if (!bus.i_alu_valid) r_ld_state <= LD_EMPTY;
        end
        default: r_ld_state <= LD_EMPTY;
      endcase
    end
  end

  // Scoreboard: the commit clears its bit first, then the issue sets its bit,
  // so a set and a clear of the same register on one edge leave it busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 32'd0;
    end else if (clk_en) begin
      if (w_commit && (w_commit_rd != 5'd0)) r_busy[w_commit_rd] <= 1'b0;
      if (w_issue_fire && (bus.i_issue_rd != 5'd0)) r_busy[bus.i_issue_rd] <= 1'b1;
    end
  end

  // Registered write port. A commit to x0 is dropped, and addr/data keep the
  // last real write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_write_en   <= 1'b0;
      r_write_addr <= 5'd0;
      r_write_data <= 32'd0;
    end else if (!clk_en) begin
      r_write_en <= 1'b0;
    end else begin
      r_write_en <= w_commit && (w_commit_rd != 5'd0);
      if (w_commit && (w_commit_rd != 5'd0)) begin
        r_write_addr <= w_commit_rd;
        r_write_data <= w_commit_data;
      end
    end
  end
endmodule

// File: tb/tb_regs_wb.sv
// Testbench for regs_wb: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_regs_wb;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  always #5 clk = ~clk;

  regs_wb_if bus ();
  regs_wb dut (.clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit          mdl_busy[32];
  bit          mdl_live = 1'b0;
  bit          buf_v;
  logic [4:0]  buf_rd;
  logic [31:0] buf_data;
  bit          exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic [36:0] exp_q[$];

  function automatic logic [31:0] ld_ext(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit          iss;
    bit          acc;
    bit          wr;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    if (!rst_n) begin
      foreach (mdl_busy[i]) mdl_busy[i] = 1'b0;
      buf_v = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      exp_q.delete();
      mdl_live = 1'b1;
    end else if (!clk_en) begin
      exp_we = 1'b0;
    end else begin
      iss = bus.i_issue_valid && ((bus.i_issue_rd == 0) || !mdl_busy[bus.i_issue_rd]);
      acc = bus.i_ld_valid && !buf_v;
      wr = 1'b0; wrd = '0; wdat = '0;
      if (bus.i_alu_valid) begin
        wr = 1'b1; wrd = bus.i_alu_rd; wdat = bus.i_alu_data;
      end else if (buf_v) begin
        wr = 1'b1; wrd = buf_rd; wdat = buf_data; buf_v = 1'b0;
      end
      exp_we = wr && (wrd != 0);
      if (exp_we) begin
        exp_addr = wrd; exp_data = wdat; mdl_busy[wrd] = 1'b0;
        exp_q.push_back({wrd, wdat});
      end
      if (iss && bus.i_issue_rd != 0) mdl_busy[bus.i_issue_rd] = 1'b1;
      if (acc) begin
        buf_v = 1'b1; buf_rd = bus.i_ld_rd;
        buf_data = ld_ext(bus.i_ld_data, bus.i_ld_funct3, bus.i_ld_offset);
      end
    end
  end

  // ---------------- per-cycle compare / scoreboard ----------------
  always @(negedge clk) begin
    logic [36:0] item;
    if (mdl_live) begin
      chk("issue_ready", bus.o_issue_ready,
          (bus.i_issue_rd == 0) || !mdl_busy[bus.i_issue_rd]);
      chk("ld_ready", bus.o_ld_ready, !buf_v);
      chk("a_busy", bus.o_a_busy, mdl_busy[bus.i_a_addr]);
      chk("b_busy", bus.o_b_busy, mdl_busy[bus.i_b_addr]);
      chk("write_en", bus.o_write_en, exp_we);
      chk("write_addr", bus.o_write_addr, exp_addr);
      chk("write_data", bus.o_write_data, exp_data);
      if (bus.o_write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("write_unexpected", 1, 0);
        end else begin
          item = exp_q.pop_front();
          chk("write_q", {bus.o_write_addr, bus.o_write_data}, item);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.i_issue_valid = 0; bus.i_issue_rd = 0;
    bus.i_alu_valid = 0; bus.i_alu_rd = 0; bus.i_alu_data = 0;
    bus.i_ld_valid = 0; bus.i_ld_rd = 0; bus.i_ld_data = 0;
    bus.i_ld_funct3 = 0; bus.i_ld_offset = 0;
    bus.i_a_addr = 0; bus.i_b_addr = 0;
  endtask

  task automatic load(logic [4:0] rd, logic [31:0] d, logic [2:0] f3, logic [1:0] off);
    bus.i_ld_valid = 1; bus.i_ld_rd = rd; bus.i_ld_data = d;
    bus.i_ld_funct3 = f3; bus.i_ld_offset = off;
  endtask

  logic [31:0] ld_word;
  logic [2:0]  tbl_f3[4]  = '{3'd0, 3'd4, 3'd1, 3'd5};
  logic [1:0]  tbl_off[4] = '{2'd1, 2'd0, 2'd2, 2'd2};
  logic [31:0] tbl_exp[4] = '{32'h0000_007F, 32'h0000_0081, 32'hFFFF_80F0, 32'h0000_80F0};

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst_n = 0; clk_en = 1;
    step(); step();
    rst_n = 1;
    #1;
    chk("rst_write_en", bus.o_write_en, 0);
    chk("rst_write_addr", bus.o_write_addr, 0);
    chk("rst_write_data", bus.o_write_data, 0);
    chk("rst_ld_ready", bus.o_ld_ready, 1);
    chk("rst_issue_ready", bus.o_issue_ready, 1);

    // Issue x5, then an ALU result to x5 on the following cycle.
    bus.i_a_addr = 5; bus.i_issue_valid = 1; bus.i_issue_rd = 5;
    step();
    chk("busy5_set", bus.o_a_busy, 1);
    bus.i_issue_valid = 0; bus.i_alu_valid = 1; bus.i_alu_rd = 5; bus.i_alu_data = 32'h1234;
    #1 chk("busy5_hold", bus.o_a_busy, 1);
    step();
    chk("alu_we", bus.o_write_en, 1);
    chk("alu_addr", bus.o_write_addr, 5);
    chk("alu_data", bus.o_write_data, 32'h0000_1234);
    chk("busy5_clr", bus.o_a_busy, 0);
    bus.i_alu_valid = 0;
    step();
    chk("alu_we_once", bus.o_write_en, 0);

    // Load extension cases for the word 0x80F07F81.
    ld_word = 32'h80F0_7F81;
    for (int i = 0; i < 4; i++) begin
      load(5'd9, ld_word, tbl_f3[i], tbl_off[i]);
      step();
      bus.i_ld_valid = 0;
      step();
      chk("ld_ext_we", bus.o_write_en, 1);
      chk("ld_ext_data", bus.o_write_data, tbl_exp[i]);
    end

    // A buffered load waits behind three back-to-back ALU results.
    load(5'd10, 32'h1122_3344, 3'd2, 2'd0);
    step();
    bus.i_ld_valid = 0;
    chk("ld_full_ready", bus.o_ld_ready, 0);
    for (int i = 0; i < 3; i++) begin
      bus.i_alu_valid = 1; bus.i_alu_rd = 5'(11 + i); bus.i_alu_data = 32'h100 + i;
      step();
      chk("arb_ld_ready", bus.o_ld_ready, 0);
      chk("arb_alu_we", bus.o_write_en, 1);
      chk("arb_alu_addr", bus.o_write_addr, 11 + i);
    end
    bus.i_alu_valid = 0;
    step();
    chk("arb_ld_we", bus.o_write_en, 1);
    chk("arb_ld_addr", bus.o_write_addr, 10);
    chk("arb_ld_data", bus.o_write_data, 32'h1122_3344);
    chk("arb_ld_ready_back", bus.o_ld_ready, 1);

    // Issue is stalled on a busy x7. Then a set and a clear of x7 on the same edge.
    bus.i_a_addr = 7; bus.i_issue_valid = 1; bus.i_issue_rd = 7;
    step();
    #1 chk("waw_stall", bus.o_issue_ready, 0);
    bus.i_alu_valid = 1; bus.i_alu_rd = 7; bus.i_alu_data = 32'h77;
    step();
    chk("busy7_cleared", bus.o_a_busy, 0);
    step();
    chk("busy7_set_wins", bus.o_a_busy, 1);
    bus.i_issue_valid = 0;
    step();
    bus.i_alu_valid = 0;

    // An ALU result to x0 is dropped, and a load offered with clk_en low is ignored.
    bus.i_alu_valid = 1; bus.i_alu_rd = 0; bus.i_alu_data = 32'hFFFF_FFFF;
    step();
    chk("x0_we", bus.o_write_en, 0);
    bus.i_alu_valid = 0;
    clk_en = 0; load(5'd12, 32'hDEAD_BEEF, 3'd2, 2'd0);
    step();
    chk("clken_ld_ready", bus.o_ld_ready, 1);
    clk_en = 1; bus.i_ld_valid = 0;
    step();
    chk("clken_no_write", bus.o_write_en, 0);

    // Reset while the buffer is full and x3 is busy.
    load(5'd3, 32'h5555_AAAA, 3'd2, 2'd0);
    bus.i_issue_valid = 1; bus.i_issue_rd = 3; bus.i_a_addr = 3;
    step();
    bus.i_ld_valid = 0; bus.i_issue_valid = 0;
    chk("pre_rst_busy3", bus.o_a_busy, 1);
    chk("pre_rst_full", bus.o_ld_ready, 0);
    rst_n = 0; bus.i_alu_valid = 1; bus.i_alu_rd = 4; bus.i_alu_data = 32'h44;
    bus.i_issue_valid = 1; bus.i_issue_rd = 6; load(5'd8, 32'h8888, 3'd2, 2'd0);
    step();
    rst_n = 1; idle(); bus.i_a_addr = 3; bus.i_b_addr = 6;
    #1;
    chk("post_rst_ld_ready", bus.o_ld_ready, 1);
    chk("post_rst_busy3", bus.o_a_busy, 0);
    chk("post_rst_busy6", bus.o_b_busy, 0);
    chk("post_rst_we", bus.o_write_en, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_write", bus.o_write_en, 0);
    end

    // Randomized traffic, checked each cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      rst_n  = ($urandom_range(0, 199) != 0);
      clk_en = ($urandom_range(0, 9) != 0);
      bus.i_issue_valid = $urandom_range(0, 1);
      bus.i_issue_rd    = 5'($urandom_range(0, 7));
      bus.i_alu_valid   = ($urandom_range(0, 2) == 0);
      bus.i_alu_rd      = 5'($urandom_range(0, 7));
      bus.i_alu_data    = $urandom;
      bus.i_ld_valid    = $urandom_range(0, 1);
      bus.i_ld_rd       = 5'($urandom_range(0, 7));
      bus.i_ld_data     = $urandom;
      bus.i_ld_funct3   = 3'($urandom_range(0, 7));
      bus.i_ld_offset   = 2'($urandom_range(0, 3));
      bus.i_a_addr      = 5'($urandom_range(0, 7));
      bus.i_b_addr      = 5'($urandom_range(0, 31));
      step();
    end
    rst_n = 1; clk_en = 1; idle();
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
